mem_sig_monitor: RTL and testbench

MEM_SIG_MONITOR -- requirements
Module: mem_sig_monitor

---
 rtl/mem_sig_monitor.sv | 181 ++++++++++++++++++
 tb/tb_mem_sig_monitor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sig_monitor.sv
// mem_sig_monitor: watches SoC memory writes for stop/trap/dump signature
// addresses, queues register dump records for a consumer and sequences the
// end of a simulation run (RUN -> DRAIN -> DONE, or straight to DONE on the
// run-length limit).
// Optional feature: define SIG_MON_FP_DUMP_EN to enable FP register dumps at
// address 0x18; without it those writes are ignored and dump_is_fp_o is 0.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_RUN   | normal operation; decoded writes acted on, cycle count runs
// S_DRAIN | stop/trap seen; counting down DRAIN_CYCLES before finishing
// S_DONE  | run finished; terminal until reset
module mem_sig_monitor #(
  parameter int unsigned DRAIN_CYCLES = 50,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter bit          TRAP_STOP    = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [63:0] mem_addr_i,
  input  logic [63:0] mem_wdata_i,
  input  logic [7:0]  mem_strb_i,
  input  logic [31:0] simlen_i,
  output logic        dump_valid_o,
  input  logic        dump_ready_i,
  output logic        dump_is_fp_o,
  output logic [4:0]  dump_idx_o,
  output logic [63:0] dump_data_o,
  output logic        done_o,
  output logic [1:0]  done_cause_o,
  output logic        trap_seen_o,
  output logic        overflow_o,
  output logic [31:0] cycle_cnt_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [PTR_W:0] PTR_ONE = 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] drain_q, drain_d;
  logic [1:0]       cause_q, cause_d;
  logic             trap_q, ovf_q;
  logic [31:0]      cyc_q;
  logic [4:0]       int_idx_q;
  logic [4:0]       rec_idx;
  logic             wr_qual, hit_stop, hit_trap, hit_int, hit_fp;
  logic             push_req, push, pop, empty, full;
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic [63:0]      fifo_data [FIFO_DEPTH];
  logic [4:0]       fifo_idx  [FIFO_DEPTH];

  // byte strobes carry no meaning for signature writes
  logic strb_unused;
  assign strb_unused = ^mem_strb_i;

  assign wr_qual  = mem_req_i && mem_we_i;
  assign hit_stop = wr_qual && (mem_addr_i == 64'h0);
  assign hit_trap = wr_qual && (mem_addr_i == 64'h8);
  assign hit_int  = wr_qual && (mem_addr_i == 64'h10);

`ifdef SIG_MON_FP_DUMP_EN
  logic [4:0] fp_idx_q;
  logic       fifo_fp [FIFO_DEPTH];

  assign hit_fp  = wr_qual && (mem_addr_i == 64'h18);
  assign rec_idx = hit_fp ? fp_idx_q : int_idx_q;

  // FP index wraps naturally 31 -> 0, advancing even when the record is dropped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) fp_idx_q <= 5'd0;
    else if (push_req && hit_fp) fp_idx_q <= fp_idx_q + 5'd1;
  end

  // FP flag storage alongside the data records
  always_ff @(posedge clk_i) begin
    if (push) fifo_fp[wr_ptr_q[PTR_W-1:0]] <= hit_fp;
  end

  assign dump_is_fp_o = fifo_fp[rd_ptr_q[PTR_W-1:0]];
`else
  assign hit_fp       = 1'b0;
  assign rec_idx      = int_idx_q;
  assign dump_is_fp_o = 1'b0;
`endif

  // dumps are only captured in RUN; a full FIFO drops unless a pop frees a slot
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {PTR_W{1'b0}}});
  assign pop      = !empty && dump_ready_i;
  assign push_req = (state_q == S_RUN) && (hit_int || hit_fp);
  assign push     = push_req && (!full || pop);

  // next-state, drain countdown and cause latch
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    cause_d = cause_q;
    unique case (state_q)
      S_RUN: begin
        if (hit_stop) begin
          state_d = S_DRAIN;
          drain_d = CNT_W'(DRAIN_CYCLES);
          cause_d = 2'd1;
        end else if (hit_trap && TRAP_STOP) begin
          state_d = S_DRAIN;
          drain_d = CNT_W'(DRAIN_CYCLES);
          cause_d = 2'd2;
        end else if ((simlen_i != 32'd0) && (cyc_q == simlen_i - 32'd1)) begin
          state_d = S_DONE;
          cause_d = 2'd3;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_DONE;
        else               drain_d = drain_q - CNT_W'(1);
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
  end

  // control state, sticky flags and the run cycle counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_RUN;
      drain_q <= '0;
      cause_q <= 2'd0;
      trap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cyc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cause_q <= cause_d;
      if ((state_q == S_RUN) && hit_trap) trap_q <= 1'b1;
      if (push_req && !push) ovf_q <= 1'b1;
      // the edge that leaves RUN is not counted, so a limit of N stops at N-1
      if ((state_q == S_RUN) && (state_d == S_RUN)) cyc_q <= cyc_q + 32'd1;
    end
  end

  // integer index runs 1..31 (x0 is never dumped), advancing even on a drop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) int_idx_q <= 5'd1;
    else if (push_req && hit_int) int_idx_q <= (int_idx_q == 5'd31) ? 5'd1 : int_idx_q + 5'd1;
  end

  // FIFO pointers; the extra MSB distinguishes full from empty
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // record storage; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr_q[PTR_W-1:0]] <= mem_wdata_i;
      fifo_idx[wr_ptr_q[PTR_W-1:0]]  <= rec_idx;
    end
  end

  assign dump_valid_o = !empty;
  assign dump_idx_o   = fifo_idx[rd_ptr_q[PTR_W-1:0]];
  assign dump_data_o  = fifo_data[rd_ptr_q[PTR_W-1:0]];
  assign done_o       = (state_q == S_DONE);
  assign done_cause_o = cause_q;
  assign trap_seen_o  = trap_q;
  assign overflow_o   = ovf_q;
  assign cycle_cnt_o  = cyc_q;

endmodule

// File: tb/tb_mem_sig_monitor.sv
// Scoreboard bench for mem_sig_monitor: a behavioural run model predicts
// status outputs and dump records; a negedge monitor compares them.
module tb_mem_sig_monitor;
  localparam int DC    = 50;
  localparam int DEPTH = 4;
  localparam bit TSTOP = 1'b0;
`ifdef SIG_MON_FP_DUMP_EN
  localparam bit FP_EN = 1'b1;
`else
  localparam bit FP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, ready;
  logic [63:0] addr, wdata;
  logic [7:0]  strb;
  logic [31:0] simlen;
  logic        dvalid, dis_fp, done, trap_seen, ovf;
  logic [4:0]  didx;
  logic [63:0] ddata;
  logic [1:0]  cause;
  logic [31:0] cyc;

  always #5 clk = ~clk;

  mem_sig_monitor #(.DRAIN_CYCLES(DC), .FIFO_DEPTH(DEPTH), .TRAP_STOP(TSTOP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req), .mem_we_i(we),
    .mem_addr_i(addr), .mem_wdata_i(wdata), .mem_strb_i(strb), .simlen_i(simlen),
    .dump_valid_o(dvalid), .dump_ready_i(ready), .dump_is_fp_o(dis_fp),
    .dump_idx_o(didx), .dump_data_o(ddata), .done_o(done), .done_cause_o(cause),
    .trap_seen_o(trap_seen), .overflow_o(ovf), .cycle_cnt_o(cyc)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  typedef struct {bit fp; int idx; logic [63:0] data;} rec_t;
  rec_t exp_q[$];

  // reference model: 0 running, 1 draining, 2 finished
  int     m_st, m_left, m_cause, m_iidx, m_fidx, m_occ;
  bit     m_trap, m_ovf;
  longint m_cyc;
  int     edge_cnt = 0;
  bit     mw, m_stop, m_trapw, m_int, m_fp, m_pop, m_push;
  rec_t   m_rec;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_left = 0; m_cause = 0; m_trap = 0; m_ovf = 0; m_cyc = 0;
      m_iidx = 1; m_fidx = 0; m_occ = 0;
      exp_q.delete();
    end else begin
      edge_cnt++;
      mw      = req && we;
      m_stop  = mw && addr == 64'h0;
      m_trapw = mw && addr == 64'h8;
      m_int   = mw && addr == 64'h10;
      m_fp    = mw && addr == 64'h18 && FP_EN;
      m_pop   = ready && m_occ > 0;
      m_push  = 0;
      if (m_st == 0) begin
        if (m_trapw) m_trap = 1;
        if (m_int || m_fp) begin
          m_rec.fp   = m_fp;
          m_rec.idx  = m_fp ? m_fidx : m_iidx;
          m_rec.data = wdata;
          if (m_occ < DEPTH || m_pop) begin exp_q.push_back(m_rec); m_push = 1; end
          else m_ovf = 1;
          if (m_fp) m_fidx = (m_fidx + 1) % 32;
          else      m_iidx = (m_iidx == 31) ? 1 : m_iidx + 1;
        end
        if (m_stop) begin m_st = 1; m_left = DC; m_cause = 1; end
        else if (m_trapw && TSTOP) begin m_st = 1; m_left = DC; m_cause = 2; end
        else if (simlen != 0 && m_cyc == longint'(simlen) - 1) begin m_st = 2; m_cause = 3; end
        else m_cyc++;
      end else if (m_st == 1) begin
        if (m_left == 0) m_st = 2;
        else m_left--;
      end
      m_occ = m_occ + int'(m_push) - int'(m_pop);
    end
  end

  // monitor: status every cycle, records whenever the consumer takes one
  rec_t got;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", dvalid, m_occ > 0);
      chk("done", done, m_st == 2);
      chk("cause", cause, m_cause);
      chk("trap_seen", trap_seen, m_trap);
      chk("overflow", ovf, m_ovf);
      chk("cycle_cnt", cyc, m_cyc);
      if (dvalid && ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rec_unexpected act idx=%0d data=%0h exp=none", didx, ddata);
        end else begin
          got = exp_q.pop_front();
          chk("rec_is_fp", dis_fp, got.fp);
          chk("rec_idx", didx, got.idx);
          chk("rec_data", ddata, got.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(logic [63:0] a, logic [63:0] d);
    req = 1; we = 1; addr = a; wdata = d; strb = 8'($urandom);
    step();
    req = 0; we = 0;
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cause"}, cause, 0);
    chk({tag, "_trap"}, trap_seen, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_cyc"}, cyc, 0);
    chk({tag, "_valid"}, dvalid, 0);
  endtask

  task automatic do_reset();
    rst_n = 0; #2;
    reset_checks("rst");
    @(negedge clk); #2 rst_n = 1;
    step();
  endtask

  task automatic wait_done(int budget, string tag);
    int n = 0;
    while (!done && n < budget) begin step(); n++; end
    chk({tag, "_done_reached"}, done, 1);
  endtask

  int stop_edge;

  initial begin
    rst_n = 1; req = 0; we = 0; addr = 0; wdata = 0; strb = 0; simlen = 0; ready = 0;
    #3 do_reset();

    // three integer dumps, then 32 more to cross the 31 -> 1 wrap
    ready = 1;
    wr(64'h10, 64'hA); wr(64'h10, 64'hB); wr(64'h10, 64'hC);
    repeat (4) step();
    for (int i = 0; i < 32; i++) wr(64'h10, {$urandom, $urandom});
    repeat (4) step();

    // randomized traffic without stop: dumps, FP, traps, near misses, reads
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ready = 1'($urandom_range(0, 1));
      wdata = {$urandom, $urandom};
      strb  = 8'($urandom);
      case ($urandom_range(0, 7))
        0, 1, 2: begin req = 1; we = 1; addr = 64'h10; end
        3:       begin req = 1; we = 1; addr = 64'h18; end
        4:       begin req = 1; we = 1; addr = 64'h8; end
        5:       begin req = 1; we = 1; addr = 64'h10 | (64'd1 << $urandom_range(32, 63)); end
        6:       begin req = 1; we = 0; addr = 64'h10; end
        default: begin req = 0; we = 1; addr = 64'h10; end
      endcase
      step();
      req = 0; we = 0;
    end
    ready = 1;
    repeat (8) step();

    // overflow: six dumps into a stalled four-entry FIFO
    do_reset();
    ready = 0;
    for (int i = 0; i < 6; i++) wr(64'h10, 64'h100 + 64'(i));
    step();
    chk("ovf_sticky", ovf, 1);
    chk("ovf_head_idx", didx, 1);
    ready = 1;
    repeat (6) step();

    // trap with TRAP_STOP=0 keeps running; later stop drains 51 edges
    do_reset();
    wr(64'h8, 64'h1);
    step();
    chk("trap_seen_set", trap_seen, 1);
    chk("trap_keeps_run", cause, 0);
    wr(64'h0, 64'h0);
    stop_edge = edge_cnt;
    wr(64'h10, 64'h55);
    wait_done(200, "stop");
    chk("stop_latency", edge_cnt - stop_edge, 51);
    chk("stop_cause", cause, 1);
    repeat (3) step();

    // reset in the middle of DRAIN, then first dump reports idx 1
    do_reset();
    wr(64'h0, 64'h0);
    repeat (10) step();
    rst_n = 0; #2;
    reset_checks("mid_drain");
    @(negedge clk); #2 rst_n = 1;
    step();
    wr(64'h10, 64'h77);
    chk("post_rst_valid", dvalid, 1);
    chk("post_rst_idx", didx, 1);
    repeat (3) step();

    // run-length limit alone
    simlen = 100;
    do_reset();
    wait_done(300, "simlen");
    chk("simlen_cause", cause, 3);
    chk("simlen_cyc", cyc, 99);

    // stop on the same edge as the limit wins
    do_reset();
    for (int n = 0; n < 300 && cyc != 99; n++) step();
    chk("simlen_reach99", cyc, 99);
    wr(64'h0, 64'h0);
    chk("tie_not_done", done, 0);
    chk("tie_cause", cause, 1);
    wait_done(100, "tie");
    simlen = 0;

    ready = 1;
    repeat (6) step();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
